// File: rtl/autotype_sequencer_if.sv
// autotype_sequencer_if: control inputs and keyboard/reset outputs of the autotype sequencer.
// The slave modport is the sequencer; the master modport is whoever drives restart/user_active.
interface autotype_sequencer_if;
    logic       restart;
    logic       user_active;
    logic       sys_reset_n;
    logic       key_b;
    logic       key_c;
    logic       key_enter;
    logic       busy;
    logic [3:0] step;
    modport master (output restart, user_active,
                    input  sys_reset_n, key_b, key_c, key_enter, busy, step);
    modport slave  (input  restart, user_active,
                    output sys_reset_n, key_b, key_c, key_enter, busy, step);
endinterface

// File: rtl/autotype_sequencer.sv
// autotype_sequencer: timed reset/boot/key-script player that yields to live keyboard activity.
// Define AUTOTYPE_LOOP_EN to replay the script forever after each successful completion.
module autotype_sequencer #(
    parameter int CLK_MHZ    = 25,
    parameter int RESET_MS   = 500,
    parameter int BOOT_MS    = 1000,
    parameter int HOLD_MS    = 200,
    parameter int GAP_MS     = 200,
    parameter int SCRIPT_LEN = 5,
    parameter logic [2*SCRIPT_LEN-1:0] SCRIPT = 10'b10_10_10_01_00
) (
    input logic                 clk,
    input logic                 n_reset,
    autotype_sequencer_if.slave bus
);
`ifdef AUTOTYPE_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    localparam logic [31:0] TICK = 32'(CLK_MHZ * 1000);
    localparam logic [31:0] SCR  = 32'(SCRIPT);
    localparam logic [3:0]  LAST = 4'(SCRIPT_LEN - 1);

    typedef enum logic [2:0] {RST_HOLD, BOOT, PRESS, RELEASE, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] pre_q, pre_d, ms_q, ms_d, dur;
    logic [3:0]  step_q, step_d;
    logic        loop_q, loop_d;
    logic        sys_reset_n_q, sys_reset_n_d;
    logic        key_b_q, key_b_d, key_c_q, key_c_d, key_enter_q, key_enter_d;
    logic        busy_q, busy_d;
    logic        expired, enter;
    logic [1:0]  code;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= RST_HOLD;
            pre_q         <= '0;
            ms_q          <= '0;
            step_q        <= '0;
            loop_q        <= 1'b0;
            sys_reset_n_q <= 1'b0;
            key_b_q       <= 1'b0;
            key_c_q       <= 1'b0;
            key_enter_q   <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            pre_q         <= pre_d;
            ms_q          <= ms_d;
            step_q        <= step_d;
            loop_q        <= loop_d;
            sys_reset_n_q <= sys_reset_n_d;
            key_b_q       <= key_b_d;
            key_c_q       <= key_c_d;
            key_enter_q   <= key_enter_d;
            busy_q        <= busy_d;
        end
    end

    // DONE uses the gap duration, which only matters for the looping replay.
    always_comb begin
        dur = state_q == RST_HOLD ? 32'(RESET_MS) :
              state_q == BOOT     ? 32'(BOOT_MS)  :
              state_q == PRESS    ? 32'(HOLD_MS)  : 32'(GAP_MS);
        expired = pre_q == TICK - 32'd1 && ms_q == dur - 32'd1;
        state_d = state_q;
        step_d  = step_q;
        loop_d  = loop_q;
        if (bus.restart) begin
            state_d = RST_HOLD;
            step_d  = '0;
            loop_d  = 1'b0;
        end else if (bus.user_active && state_q inside {BOOT, PRESS, RELEASE}) begin
            state_d = DONE;
        end else if (expired) begin
            case (state_q)
                RST_HOLD: state_d = BOOT;
                BOOT: begin
                    state_d = PRESS;
                    step_d  = '0;
                end
                PRESS:    state_d = RELEASE;
                RELEASE: begin
                    state_d = step_q == LAST ? DONE : PRESS;
                    step_d  = step_q == LAST ? step_q : step_q + 4'd1;
                    loop_d  = step_q == LAST;
                end
                DONE: if (LOOP && loop_q) begin
                    state_d = RST_HOLD;
                    step_d  = '0;
                    loop_d  = 1'b0;
                end
                default: ;
            endcase
        end
        enter = bus.restart || state_d != state_q;
        pre_d = enter || pre_q == TICK - 32'd1 ? '0 : pre_q + 32'd1;
        ms_d  = enter ? '0 : pre_q == TICK - 32'd1 ? ms_q + 32'd1 : ms_q;
    end

    always_comb begin
        code          = SCR[{step_d, 1'b0} +: 2];
        sys_reset_n_d = state_d != RST_HOLD;
        key_b_d       = state_d == PRESS && code == 2'd0;
        key_c_d       = state_d == PRESS && code == 2'd1;
        key_enter_d   = state_d == PRESS && code == 2'd2;
        busy_d        = state_d != DONE;
    end

    assign bus.sys_reset_n = sys_reset_n_q;
    assign bus.key_b       = key_b_q;
    assign bus.key_c       = key_c_q;
    assign bus.key_enter   = key_enter_q;
    assign bus.busy        = busy_q;
    assign bus.step        = step_q;
endmodule

// File: tb/tb_autotype_sequencer.sv
// tb_autotype_sequencer: timeline-table and randomized checks of two sequencer instances
// (default script and a single delay-only entry) against a cycle-count reference model.
module tb_autotype_sequencer;
    localparam int R = 4000, B = 3000, H = 2000, G = 2000, P = H + G;
    localparam int S = 27006, T = 66508;
    localparam int LAST_TBL = T + 11101;
    localparam int NCYC = LAST_TBL + 1 + 9000;

    typedef struct packed {
        logic       sys;
        logic       kb;
        logic       kc;
        logic       ke;
        logic       busy;
        logic [3:0] step;
    } out_t;

    typedef struct {
        int   cyc;
        bit   rs;
        bit   ua;
        out_t exp;
        bit   c2;
        out_t exp2;
    } vec_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    autotype_sequencer_if ifa();
    autotype_sequencer_if ifb();

    autotype_sequencer #(.CLK_MHZ(1), .RESET_MS(4), .BOOT_MS(3), .HOLD_MS(2), .GAP_MS(2))
        dut_a (.clk(clk), .n_reset(n_reset), .bus(ifa.slave));
    autotype_sequencer #(.CLK_MHZ(1), .RESET_MS(4), .BOOT_MS(3), .HOLD_MS(2), .GAP_MS(2),
                         .SCRIPT_LEN(1), .SCRIPT(2'b11))
        dut_b (.clk(clk), .n_reset(n_reset), .bus(ifb.slave));

    int          mt[2];
    bit          mab[2];
    int          mabs[2];
    int          mlen[2] = '{5, 1};
    logic [31:0] mscr[2] = '{32'h2A4, 32'h3};
    int          n_cmp = 0, n_bad = 0;
    vec_t        tbl[$];

    function automatic out_t mk(bit s, bit b, bit c, bit e, bit bz, int st);
        return out_t'({s, b, c, e, bz, 4'(st)});
    endfunction

    // Expected outputs from elapsed cycles since the sequence (re)started.
    function automatic out_t predict(int k);
        int u, i;
        logic [31:0] scr;
        logic [1:0] code;
        if (mab[k]) return mk(1, 0, 0, 0, 0, mabs[k]);
        if (mt[k] < R) return mk(0, 0, 0, 0, 1, 0);
        if (mt[k] < R + B) return mk(1, 0, 0, 0, 1, 0);
        u = mt[k] - R - B;
        i = u / P;
        if (i >= mlen[k]) return mk(1, 0, 0, 0, 0, mlen[k] - 1);
        if (u % P >= H) return mk(1, 0, 0, 0, 1, i);
        scr = mscr[k];
        code = scr[2*i +: 2];
        return mk(1, code == 2'd0, code == 2'd1, code == 2'd2, 1, i);
    endfunction

    task automatic advance(int k, bit rs, bit ua);
        out_t o;
        o = predict(k);
        if (rs) begin
            mt[k] = 0;
            mab[k] = 1'b0;
        end else if (ua && o.sys && o.busy) begin
            mab[k] = 1'b1;
            mabs[k] = int'(o.step);
        end else if (!mab[k]) begin
`ifdef AUTOTYPE_LOOP_EN
            mt[k] = (mt[k] == R + B + mlen[k] * P + G - 1) ? 0 : mt[k] + 1;
`else
            mt[k] = mt[k] + 1;
`endif
        end
    endtask

    function automatic out_t got(int k);
        return k == 0 ? out_t'({ifa.sys_reset_n, ifa.key_b, ifa.key_c, ifa.key_enter, ifa.busy, ifa.step})
                      : out_t'({ifb.sys_reset_n, ifb.key_b, ifb.key_c, ifb.key_enter, ifb.busy, ifb.step});
    endfunction

    function automatic bit quiet(int k);
        out_t o;
        o = predict(k);
        return !o.sys || !o.busy;
    endfunction

    task automatic check(string name, int cyc, out_t g, out_t e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got{sys,b,c,ent,busy,step}=%b expected=%b", name, cyc, g, e);
        end
    endtask

    task automatic add(int c, bit rs, bit ua, out_t e);
        tbl.push_back('{c, rs, ua, e, 1'b0, '0});
    endtask

    task automatic add2(out_t e2);
        tbl[tbl.size()-1].c2 = 1'b1;
        tbl[tbl.size()-1].exp2 = e2;
    endtask

    initial begin
        bit rs, ua;
        int vi;
        vi = 0;
        ifa.restart = 1'b0; ifa.user_active = 1'b0;
        ifb.restart = 1'b0; ifb.user_active = 1'b0;
        add(0, 0, 0, mk(0, 0, 0, 0, 1, 0)); add2(mk(0, 0, 0, 0, 1, 0));
        add(3999, 0, 0, mk(0, 0, 0, 0, 1, 0));
        add(4000, 0, 0, mk(1, 0, 0, 0, 1, 0));
        add(6999, 0, 0, mk(1, 0, 0, 0, 1, 0));
        add(7000, 0, 0, mk(1, 1, 0, 0, 1, 0));
        add(8999, 0, 0, mk(1, 1, 0, 0, 1, 0));
        add(9000, 0, 0, mk(1, 0, 0, 0, 1, 0));
        add(10999, 0, 0, mk(1, 0, 0, 0, 1, 0)); add2(mk(1, 0, 0, 0, 1, 0));
        add(11000, 0, 0, mk(1, 0, 1, 0, 1, 1)); add2(mk(1, 0, 0, 0, 0, 0));
        add(12999, 0, 0, mk(1, 0, 1, 0, 1, 1));
        add(13000, 0, 0, mk(1, 0, 0, 0, 1, 1));
        add(15000, 0, 0, mk(1, 0, 0, 1, 1, 2));
        add(16999, 0, 0, mk(1, 0, 0, 1, 1, 2));
        add(19000, 0, 0, mk(1, 0, 0, 1, 1, 3));
        add(23000, 0, 0, mk(1, 0, 0, 1, 1, 4));
        add(24999, 0, 0, mk(1, 0, 0, 1, 1, 4));
        add(25000, 0, 0, mk(1, 0, 0, 0, 1, 4));
        add(26999, 0, 0, mk(1, 0, 0, 0, 1, 4));
        add(27000, 0, 0, mk(1, 0, 0, 0, 0, 4));
        add(S - 1, 1, 0, mk(1, 0, 0, 0, 0, 4));
        add(S, 0, 0, mk(0, 0, 0, 0, 1, 0));
        add(S + 3999, 0, 0, mk(0, 0, 0, 0, 1, 0));
        add(S + 4000, 0, 0, mk(1, 0, 0, 0, 1, 0));
        add(S + 7000, 0, 0, mk(1, 1, 0, 0, 1, 0));
        add(S + 11000, 0, 0, mk(1, 0, 1, 0, 1, 1));
        add(S + 15000, 0, 0, mk(1, 0, 0, 1, 1, 2));
        add(S + 19000, 0, 0, mk(1, 0, 0, 1, 1, 3));
        add(S + 19500, 0, 1, mk(1, 0, 0, 1, 1, 3));
        add(S + 19501, 0, 0, mk(1, 0, 0, 0, 0, 3));
        add(T - 1, 1, 0, mk(1, 0, 0, 0, 0, 3));
        add(T, 0, 0, mk(0, 0, 0, 0, 1, 0));
        add(T + 7100, 1, 1, mk(1, 1, 0, 0, 1, 0));
        add(T + 7101, 0, 0, mk(0, 0, 0, 0, 1, 0));
        add(T + 11100, 0, 0, mk(0, 0, 0, 0, 1, 0));
        add(LAST_TBL, 0, 0, mk(1, 0, 0, 0, 1, 0));
        for (int k = 0; k < 2; k++) begin
            mt[k] = 0; mab[k] = 1'b0; mabs[k] = 0;
        end
        repeat (3) @(negedge clk);
        check("reset_hold_a", -1, got(0), mk(0, 0, 0, 0, 1, 0));
        check("reset_hold_b", -1, got(1), mk(0, 0, 0, 0, 1, 0));
        n_reset = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            check("model_a", cyc, got(0), predict(0));
            check("model_b", cyc, got(1), predict(1));
            rs = 1'b0;
            ua = 1'b0;
            if (vi < tbl.size() && tbl[vi].cyc == cyc) begin
                check("table_a", cyc, got(0), tbl[vi].exp);
                if (tbl[vi].c2) check("table_b", cyc, got(1), tbl[vi].exp2);
                rs = tbl[vi].rs;
                ua = tbl[vi].ua;
                vi++;
            end else if (cyc > LAST_TBL) begin
                rs = $urandom_range(0, 2999) == 0;
                ua = $urandom_range(0, 399) == 0;
            end else if (quiet(0) && quiet(1)) begin
                ua = $urandom_range(0, 49) == 0;
            end
            ifa.restart = rs; ifa.user_active = ua;
            ifb.restart = rs; ifb.user_active = ua;
            @(posedge clk);
            advance(0, rs, ua);
            advance(1, rs, ua);
            @(negedge clk);
        end
        n_cmp++;
        if (vi != tbl.size()) begin
            n_bad++;
            $display("FAIL table_done applied=%0d required=%0d", vi, tbl.size());
        end
        ifa.restart = 1'b0; ifa.user_active = 1'b0;
        ifb.restart = 1'b0; ifb.user_active = 1'b0;
        n_reset = 1'b0;
        #1;
        check("async_reset_a", NCYC, got(0), mk(0, 0, 0, 0, 1, 0));
        check("async_reset_b", NCYC, got(1), mk(0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 2; k++) begin
            mt[k] = 0; mab[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            check("rerun_a", cyc, got(0), predict(0));
            check("rerun_b", cyc, got(1), predict(1));
            @(posedge clk);
            advance(0, 1'b0, 1'b0);
            advance(1, 1'b0, 1'b0);
            @(negedge clk);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
